// File: rtl/vec_regfile.sv
// vec_regfile: NREGS x VLEN vector register file with NRD registered read ports and NWR byte-strobed write ports.
// Optional macro VSI_RF_BYPASS_EN forwards same-cycle writes into reads; when undefined, reads return pre-write data.
module vec_regfile #(
    parameter int NREGS       = 32,
    parameter int VLEN        = 128,
    parameter int NRD         = 8,
    parameter int NWR         = 4,
    parameter int CLR_PER_CYC = 4,
    localparam int AW         = $clog2(NREGS),
    localparam int NB         = VLEN / 8
) (
    input  logic                          vsi_clk,
    input  logic                          vsi_rst,
    input  logic [NRD-1:0][AW-1:0]        vsi_rf_raddr,
    output logic [NRD-1:0][VLEN-1:0]      vsi_rf_rdata,
    input  logic [NWR-1:0][AW-1:0]        vsi_rf_waddr,
    input  logic [NWR-1:0][NB-1:0]        vsi_rf_wstrb,
    input  logic [NWR-1:0][VLEN-1:0]      vsi_rf_wdata,
    output logic                          vsi_rf_ready,
    output logic                          vsi_rf_wconflict
);
    localparam int NCLR = NREGS / CLR_PER_CYC;
    localparam int CW   = (NCLR > 1) ? $clog2(NCLR) : 1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]      state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [VLEN-1:0] mem [NREGS];
    logic [VLEN-1:0] rd_val [NRD];
    logic            conflict;

    // Any pair of ports hitting the same byte of the same register is a conflict.
    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < NWR; i++) begin
            for (int j = i + 1; j < NWR; j++) begin
                if ((vsi_rf_waddr[i] == vsi_rf_waddr[j]) &&
                    ((vsi_rf_wstrb[i] & vsi_rf_wstrb[j]) != '0)) begin
                    conflict = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge vsi_clk) begin
        if (vsi_rst) begin
            state_reg        <= ST_INIT;
            cnt_reg          <= '0;
            vsi_rf_ready     <= 1'b0;
            vsi_rf_wconflict <= 1'b0;
        end else if (state_reg == ST_INIT) begin
            for (int i = 0; i < CLR_PER_CYC; i++) begin
                mem[AW'(int'(cnt_reg) * CLR_PER_CYC + i)] <= '0;
            end
            cnt_reg          <= cnt_reg + 1'b1;
            vsi_rf_wconflict <= 1'b0;
            if (cnt_reg == CW'(NCLR - 1)) begin
                state_reg    <= ST_RUN;
                vsi_rf_ready <= 1'b1;
            end
        end else begin
            // Descending port order so the lowest index is the last assignment and wins.
            for (int w = NWR - 1; w >= 0; w--) begin
                for (int b = 0; b < NB; b++) begin
                    if (vsi_rf_wstrb[w][b]) begin
                        mem[vsi_rf_waddr[w]][8*b +: 8] <= vsi_rf_wdata[w][8*b +: 8];
                    end
                end
            end
            vsi_rf_wconflict <= conflict;
        end
    end

`ifdef VSI_RF_BYPASS_EN
    // Overlay this cycle's strobed write bytes onto the stored row, lowest port winning.
    function automatic logic [VLEN-1:0] merge_row(
        input logic [AW-1:0]               addr,
        input logic [VLEN-1:0]             base,
        input logic [NWR-1:0][AW-1:0]      wa,
        input logic [NWR-1:0][NB-1:0]      ws,
        input logic [NWR-1:0][VLEN-1:0]    wd
    );
        logic [VLEN-1:0] row;
        row = base;
        for (int w = NWR - 1; w >= 0; w--) begin
            if (wa[w] == addr) begin
                for (int b = 0; b < NB; b++) begin
                    if (ws[w][b]) begin
                        row[8*b +: 8] = wd[w][8*b +: 8];
                    end
                end
            end
        end
        return row;
    endfunction

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        assign rd_val[gi] = merge_row(vsi_rf_raddr[gi], mem[vsi_rf_raddr[gi]],
                                      vsi_rf_waddr, vsi_rf_wstrb, vsi_rf_wdata);
    end
`else
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        assign rd_val[gi] = mem[vsi_rf_raddr[gi]];
    end
`endif

    always_ff @(posedge vsi_clk) begin
        if (vsi_rst || (state_reg == ST_INIT)) begin
            vsi_rf_rdata <= '0;
        end else begin
            for (int p = 0; p < NRD; p++) begin
                vsi_rf_rdata[p] <= rd_val[p];
            end
        end
    end

endmodule
